// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue-side controller for the RV32I integer ALU. It accepts one decoded
// instruction per handshake and translates opcode/funct3/funct7[5] into a
// 3-bit alu_control. It also registers the ALU operands and captures the
// ALU result and flags. From the flags it builds SLT/SLTU results and branch
// decisions, then presents one result beat to writeback/PC-update.
//
// Sequence per op: IDLE (accept) -> EXEC (ALU evaluates) -> DONE (beat held
// until out_ready). With out_ready held high the controller issues one op
// every three cycles.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   in_valid/ready  instruction handshake (ready only in IDLE, out of reset)
//   in_opcode       instr[6:0]
//   in_funct3       instr[14:12]
//   in_funct7_5     instr[30]
//   in_rs1_val      rs1 operand
//   in_rs2_val      rs2 operand
//   in_imm          sign-extended I/B immediate
//   in_rd           destination register
//   alu_a, alu_b    registered ALU operands
//   alu_control     000 add, 001 sub, 010 and, 011 or,
//                   100 xor, 101 srl, 110 sra, 111 sll
//   alu_result      combinational ALU result
//   alu_flag        {N,Z,C,V}; C=1 after a-b means borrow (a<b unsigned)
//   out_valid/ready result beat handshake
//   out_result      writeback value
//   out_rd          destination register
//   out_we          register write enable
//   out_branch      beat is a branch
//   out_taken       branch taken
//   out_illegal     unsupported encoding
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int XLEN            = 32,
    parameter bit ILLEGAL_WB_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [XLEN-1:0] in_rs2_val,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    input  logic [3:0]      alu_flag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_branch,
    output logic            out_taken,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SRA = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    // The op tag tells the EXEC stage how to turn the raw ALU output into
    // a writeback value or a branch decision.
    typedef enum logic [2:0] {
        OP_ALU,
        OP_SLT,
        OP_SLTU,
        OP_BRANCH,
        OP_ILLEGAL
    } op_t;

    state_t          state;
    op_t             op_q;
    logic [2:0]      br_f3_q;
    logic [4:0]      rd_q;

    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [2:0]      dec_ctrl;
    op_t             dec_op;

    logic            lt_s;
    logic [XLEN-1:0] res_n;
    logic            we_n;
    logic            br_n;
    logic            taken_n;
    logic            ill_n;

    // V is not used: the signed compare is rebuilt from the operand signs.
    logic            unused_flag_v;
    assign unused_flag_v = alu_flag[0];

    assign in_ready = rst & (state == IDLE);

    // Instruction decode. R-type and I-type share one funct3 map. They
    // differ in the b source, in sub being R-only, and in the shift amount
    // being masked from rs2 or from the immediate.
    always_comb begin
        dec_a    = in_rs1_val;
        dec_b    = in_rs2_val;
        dec_ctrl = ALU_ADD;
        dec_op   = OP_ILLEGAL;
        if (in_opcode == OPC_R || in_opcode == OPC_I) begin
            dec_op = OP_ALU;
            if (in_opcode == OPC_I) begin
                dec_b = in_imm;
            end
            case (in_funct3)
                3'b000: dec_ctrl = (in_opcode == OPC_R && in_funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001: begin
                    dec_ctrl = ALU_SLL;
                    dec_b    = {{(XLEN-5){1'b0}}, dec_b[4:0]};
                end
                3'b010: begin
                    dec_ctrl = ALU_SUB;
                    dec_op   = OP_SLT;
                end
                3'b011: begin
                    dec_ctrl = ALU_SUB;
                    dec_op   = OP_SLTU;
                end
                3'b100: dec_ctrl = ALU_XOR;
                3'b101: begin
                    dec_ctrl = in_funct7_5 ? ALU_SRA : ALU_SRL;
                    dec_b    = {{(XLEN-5){1'b0}}, dec_b[4:0]};
                end
                3'b110: dec_ctrl = ALU_OR;
                default: dec_ctrl = ALU_AND;
            endcase
        end else if (in_opcode == OPC_B) begin
            dec_ctrl = ALU_SUB;
            dec_op   = (in_funct3 == 3'b010 || in_funct3 == 3'b011) ? OP_ILLEGAL : OP_BRANCH;
        end
    end

    // Result shaping from the captured ALU outputs. The signed less-than
    // uses the operand signs when they differ. This makes it correct when
    // the subtraction overflows, without looking at V.
    always_comb begin
        lt_s    = (alu_a[XLEN-1] != alu_b[XLEN-1]) ? alu_a[XLEN-1] : alu_flag[3];
        res_n   = alu_result;
        we_n    = 1'b0;
        br_n    = 1'b0;
        taken_n = 1'b0;
        ill_n   = 1'b0;
        case (op_q)
            OP_ALU: begin
                we_n = (rd_q != 5'd0);
            end
            OP_SLT: begin
                res_n = {{(XLEN-1){1'b0}}, lt_s};
                we_n  = (rd_q != 5'd0);
            end
            OP_SLTU: begin
                res_n = {{(XLEN-1){1'b0}}, alu_flag[1]};
                we_n  = (rd_q != 5'd0);
            end
            OP_BRANCH: begin
                res_n = '0;
                br_n  = 1'b1;
                case (br_f3_q)
                    3'b000:  taken_n = alu_flag[2];
                    3'b001:  taken_n = ~alu_flag[2];
                    3'b100:  taken_n = lt_s;
                    3'b101:  taken_n = ~lt_s;
                    3'b110:  taken_n = alu_flag[1];
                    3'b111:  taken_n = ~alu_flag[1];
                    default: taken_n = 1'b0;
                endcase
            end
            default: begin
                ill_n = 1'b1;
                res_n = ILLEGAL_WB_ZERO ? '0 : alu_result;
            end
        endcase
    end

    // Control FSM with registered outputs. The out_* registers are written
    // only on the EXEC edge. They therefore hold steady for as long as DONE
    // waits on out_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            op_q        <= OP_ILLEGAL;
            br_f3_q     <= 3'b000;
            rd_q        <= 5'd0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= 3'b000;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_rd      <= 5'd0;
            out_we      <= 1'b0;
            out_branch  <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_a       <= dec_a;
                        alu_b       <= dec_b;
                        alu_control <= dec_ctrl;
                        op_q        <= dec_op;
                        br_f3_q     <= in_funct3;
                        rd_q        <= in_rd;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    out_valid   <= 1'b1;
                    out_result  <= res_n;
                    out_rd      <= rd_q;
                    out_we      <= we_n;
                    out_branch  <= br_n;
                    out_taken   <= taken_n;
                    out_illegal <= ill_n;
                    state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Directed bench for alu_issue_ctrl. A behavioural combinational ALU sits
// on the alu_* side. Each issued op pushes its hand-computed expected beat
// into a scoreboard queue. A monitor process pops and compares on every
// out_valid & out_ready handshake.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] OPC_B = 7'b1100011;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        branch;
        logic        taken;
        logic        illegal;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_control;
    logic [31:0] alu_result;
    logic [3:0]  alu_flag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_branch;
    logic        out_taken;
    logic        out_illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    alu_issue_ctrl #(
        .XLEN(32),
        .ILLEGAL_WB_ZERO(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_opcode(in_opcode),
        .in_funct3(in_funct3),
        .in_funct7_5(in_funct7_5),
        .in_rs1_val(in_rs1_val),
        .in_rs2_val(in_rs2_val),
        .in_imm(in_imm),
        .in_rd(in_rd),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_control(alu_control),
        .alu_result(alu_result),
        .alu_flag(alu_flag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_rd(out_rd),
        .out_we(out_we),
        .out_branch(out_branch),
        .out_taken(out_taken),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RV32 ALU: flags {N,Z,C,V}; for sub C is the borrow.
    always_comb begin
        logic [32:0] wide;
        logic        c;
        logic        v;
        wide = 33'd0;
        c    = 1'b0;
        v    = 1'b0;
        case (alu_control)
            3'b000: begin
                wide       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = wide[31:0];
                c          = wide[32];
                v          = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b001: begin
                alu_result = alu_a - alu_b;
                c          = (alu_a < alu_b);
                v          = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = alu_a >> alu_b[4:0];
            3'b110:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            default: alu_result = alu_a << alu_b[4:0];
        endcase
        alu_flag = {alu_result[31], (alu_result == 32'd0), c, v};
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic exp_t mkExp(input logic [31:0] result, input logic [4:0] rd,
                                   input logic we, input logic br, input logic tk, input logic ill);
        exp_t e;
        e.result  = result;
        e.rd      = rd;
        e.we      = we;
        e.branch  = br;
        e.taken   = tk;
        e.illegal = ill;
        return e;
    endfunction

    // Waits (bounded) for in_ready, then offers the op for one cycle. It
    // returns #1 after the accept edge, with the DUT in EXEC.
    task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [4:0] rd,
                                 input bit push, input exp_t e);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        end
        if (push) sb_q.push_back(e);
        in_opcode   = opc;
        in_funct3   = f3;
        in_funct7_5 = f7;
        in_rs1_val  = rs1;
        in_rs2_val  = rs2;
        in_imm      = imm;
        in_rd       = rd;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency check: no beat while in EXEC, beat on the following cycle.
    // Then wait for the handshake edge to return the DUT to IDLE.
    task automatic finishOp(input string name);
        checkOutput({name, "_lat_exec"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({name, "_lat_done"}, {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input string name, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [4:0] rd, input exp_t e);
        applyStimulus(opc, f3, f7, rs1, rs2, imm, rd, 1'b1, e);
        finishOp(name);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("sb_result",  out_result, e.result);
                    checkOutput("sb_rd",      {27'd0, out_rd}, {27'd0, e.rd});
                    checkOutput("sb_we",      {31'd0, out_we}, {31'd0, e.we});
                    checkOutput("sb_branch",  {31'd0, out_branch}, {31'd0, e.branch});
                    checkOutput("sb_taken",   {31'd0, out_taken}, {31'd0, e.taken});
                    checkOutput("sb_illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t none;
        none = mkExp(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_opcode   = 7'd0;
        in_funct3   = 3'd0;
        in_funct7_5 = 1'b0;
        in_rs1_val  = 32'd0;
        in_rs2_val  = 32'd0;
        in_imm      = 32'd0;
        in_rd       = 5'd0;
        out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_alu_a",     alu_a, 32'd0);
        checkOutput("rst_alu_ctrl",  {29'd0, alu_control}, 32'd0);
        checkOutput("rst_out_result", out_result, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        runOp("add_rd5", OPC_R, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd5,
              mkExp(32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
        runOp("add_rd0", OPC_R, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd0,
              mkExp(32'h8000_0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        runOp("sub", OPC_R, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 5'd2,
              mkExp(32'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0));
        runOp("addi_f7", OPC_I, 3'b000, 1'b1, 32'd10, 32'd99, 32'h0000_0400, 5'd4,
              mkExp(32'h0000_040A, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        runOp("slt_neg", OPC_R, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3,
              mkExp(32'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        runOp("sltu", OPC_R, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3,
              mkExp(32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        runOp("slt_ovf", OPC_R, 3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 5'd6,
              mkExp(32'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
        runOp("beq", OPC_B, 3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        runOp("bne", OPC_B, 3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        runOp("bge", OPC_B, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        runOp("blt", OPC_B, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        runOp("bltu", OPC_B, 3'b110, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        runOp("bgeu", OPC_B, 3'b111, 1'b0, 32'd3, 32'd3, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0));

        applyStimulus(OPC_I, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404, 5'd8, 1'b1,
                      mkExp(32'hF800_0000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0));
        checkOutput("srai_alu_b", alu_b, 32'd4);
        checkOutput("srai_ctrl", {29'd0, alu_control}, 32'd6);
        finishOp("srai");

        applyStimulus(OPC_R, 3'b001, 1'b0, 32'd3, 32'h0000_0021, 32'd0, 5'd9, 1'b1,
                      mkExp(32'd6, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0));
        checkOutput("sll_alu_b", alu_b, 32'd1);
        checkOutput("sll_ctrl", {29'd0, alu_control}, 32'd7);
        finishOp("sll");

        // Backpressure: hold the beat for 5 cycles with a competing offer.
        out_ready = 1'b0;
        applyStimulus(OPC_R, 3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 5'd11, 1'b1,
                      mkExp(32'h0000_FF00, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        in_opcode  = OPC_R;
        in_funct3  = 3'b000;
        in_rs1_val = 32'd1;
        in_rs2_val = 32'd1;
        in_rd      = 5'd12;
        in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid",    {31'd0, out_valid}, 32'd1);
            checkOutput("bp_result",   out_result, 32'h0000_FF00);
            checkOutput("bp_rd",       {27'd0, out_rd}, 32'd11);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);

        runOp("illegal_opc", 7'h0F, 3'b000, 1'b0, 32'd7, 32'd9, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        runOp("illegal_br", OPC_B, 3'b010, 1'b0, 32'd7, 32'd9, 32'd0, 5'd0,
              mkExp(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));

        // Reset while in EXEC: the op must vanish without a beat.
        applyStimulus(OPC_R, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd13, 1'b0, none);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_valid",    {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mid_rst_alu_a",    alu_a, 32'd0);
        checkOutput("mid_rst_alu_b",    alu_b, 32'd0);
        checkOutput("mid_rst_result",   out_result, 32'd0);
        checkOutput("mid_rst_flags",
                    {26'd0, out_rd == 5'd0 ? 1'b0 : 1'b1, out_we, out_branch, out_taken, out_illegal, 1'b0},
                    32'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_in_ready2", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_mid_rst_ready", {31'd0, in_ready}, 32'd1);

        runOp("after_rst_or", OPC_I, 3'b110, 1'b0, 32'h0000_0F00, 32'd0, 32'h0000_00F0, 5'd14,
              mkExp(32'h0000_0FF0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0));

        repeat (5) @(posedge clk);
        #1;
        checkOutput("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
